// File: rtl/com_csr_arb.sv
`default_nettype none
// ============================================================================
// Module      : com_csr_arb
// Description : Round-robin arbiter that lets NM CSR masters share one CSR
//               slave port. One transaction is outstanding at a time. The
//               slave's acknowledge and read data go back to the owning
//               master. A timeout completes any transaction the slave never
//               acknowledges, and returns an error response.
//
// Ports       : clk, rst (async, active-high), clear (sync, same effect)
//               m_vld/m_wr/m_addr/m_wdata : packed per-master requests
//               m_ack (one-hot pulse), m_err, m_rdata : responses
//               s_vld/s_wr/s_addr/s_wdata, s_ack/s_rdata : slave port
//               busy, gnt_idx, to_cnt : status
// Revision    : 1.0 - initial release
// ============================================================================
module com_csr_arb #(
    parameter int              NM       = 2,
    parameter int              AW       = 20,
    parameter int              DW       = 32,
    parameter int              TIMEOUT  = 255,
    parameter logic [DW-1:0]   ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [NM-1:0]           m_vld,
    input  logic [NM-1:0]           m_wr,
    input  logic [NM*AW-1:0]        m_addr,
    input  logic [NM*DW-1:0]        m_wdata,
    output logic [NM-1:0]           m_ack,
    output logic                    m_err,
    output logic [DW-1:0]           m_rdata,
    output logic                    s_vld,
    output logic                    s_wr,
    output logic [AW-1:0]           s_addr,
    output logic [DW-1:0]           s_wdata,
    input  logic                    s_ack,
    input  logic [DW-1:0]           s_rdata,
    output logic                    busy,
    output logic [$clog2(NM)-1:0]   gnt_idx,
    output logic [15:0]             to_cnt
);

    localparam int             IW      = $clog2(NM);
    localparam int             CW      = 16;
    localparam bit             TO_EN   = (TIMEOUT != 0);
    // Last wait-counter value before the timeout fires; unused when disabled.
    localparam logic [CW-1:0]  TO_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state,   w_state_nxt;
    logic [IW-1:0]   r_ptr,     w_ptr_nxt;
    logic [CW-1:0]   r_wait,    w_wait_nxt;
    logic [IW-1:0]   r_gnt,     w_gnt_nxt;
    logic            r_s_vld,   w_s_vld_nxt;
    logic            r_s_wr,    w_s_wr_nxt;
    logic [AW-1:0]   r_s_addr,  w_s_addr_nxt;
    logic [DW-1:0]   r_s_wdata, w_s_wdata_nxt;
    logic [NM-1:0]   r_m_ack,   w_m_ack_nxt;
    logic            r_m_err,   w_m_err_nxt;
    logic [DW-1:0]   r_m_rdata, w_m_rdata_nxt;
    logic            r_busy,    w_busy_nxt;
    logic [CW-1:0]   r_to_cnt,  w_to_cnt_nxt;

    logic            w_found;
    logic [IW-1:0]   w_sel;
    int              w_cand;
    logic            w_timeout;

    // ------------------------------------------------------------------------
    // Round-robin search. Candidates are scanned from the farthest offset to
    // the nearest, so the last hit (smallest offset from r_ptr) wins.
    // ------------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = 0;
        for (int i = NM - 1; i >= 0; i--) begin
            w_cand = int'(r_ptr) + i;
            if (w_cand >= NM) begin
                w_cand = w_cand - NM;
            end
            if (m_vld[w_cand]) begin
                w_found = 1'b1;
                w_sel   = IW'(w_cand);
            end
        end
    end

    // s_ack has priority over the timeout, so it is folded in here.
    assign w_timeout = TO_EN && !s_ack && (r_wait == TO_LAST);

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_wait_nxt    = r_wait;
        w_gnt_nxt     = r_gnt;
        w_s_vld_nxt   = r_s_vld;
        w_s_wr_nxt    = r_s_wr;
        w_s_addr_nxt  = r_s_addr;
        w_s_wdata_nxt = r_s_wdata;
        w_m_ack_nxt   = r_m_ack;
        w_m_err_nxt   = r_m_err;
        w_m_rdata_nxt = r_m_rdata;
        w_to_cnt_nxt  = r_to_cnt;

        case (r_state)
            S_IDLE: begin
                // A stray s_ack here belongs to a timed-out transaction.
                if (w_found) begin
                    w_gnt_nxt     = w_sel;
                    w_s_wr_nxt    = m_wr[w_sel];
                    w_s_addr_nxt  = m_addr[int'(w_sel)*AW +: AW];
                    w_s_wdata_nxt = m_wdata[int'(w_sel)*DW +: DW];
                    w_s_vld_nxt   = 1'b1;
                    w_wait_nxt    = '0;
                    w_state_nxt   = S_BUSY;
                end
            end
            S_BUSY: begin
                w_wait_nxt = r_wait + 1'b1;
                if (s_ack) begin
                    w_s_vld_nxt          = 1'b0;
                    w_m_rdata_nxt        = s_rdata;
                    w_m_err_nxt          = 1'b0;
                    w_m_ack_nxt          = '0;
                    w_m_ack_nxt[r_gnt]   = 1'b1;
                    w_state_nxt          = S_DONE;
                end else if (w_timeout) begin
                    w_s_vld_nxt          = 1'b0;
                    w_m_rdata_nxt        = ERR_DATA;
                    w_m_err_nxt          = 1'b1;
                    w_m_ack_nxt          = '0;
                    w_m_ack_nxt[r_gnt]   = 1'b1;
                    w_to_cnt_nxt         = (r_to_cnt == '1) ? r_to_cnt : r_to_cnt + 1'b1;
                    w_state_nxt          = S_DONE;
                end
            end
            S_DONE: begin
                // Bubble cycle: the acked master drops m_vld before the next
                // arbitration sees it.
                w_ptr_nxt   = (r_gnt == IW'(NM - 1)) ? '0 : r_gnt + 1'b1;
                w_m_ack_nxt = '0;
                w_m_err_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);

        if (clear) begin
            w_state_nxt   = S_IDLE;
            w_ptr_nxt     = '0;
            w_wait_nxt    = '0;
            w_gnt_nxt     = '0;
            w_s_vld_nxt   = 1'b0;
            w_s_wr_nxt    = 1'b0;
            w_s_addr_nxt  = '0;
            w_s_wdata_nxt = '0;
            w_m_ack_nxt   = '0;
            w_m_err_nxt   = 1'b0;
            w_m_rdata_nxt = '0;
            w_busy_nxt    = 1'b0;
            w_to_cnt_nxt  = '0;
        end
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_wait    <= '0;
            r_gnt     <= '0;
            r_s_vld   <= 1'b0;
            r_s_wr    <= 1'b0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_m_ack   <= '0;
            r_m_err   <= 1'b0;
            r_m_rdata <= '0;
            r_busy    <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_wait    <= w_wait_nxt;
            r_gnt     <= w_gnt_nxt;
            r_s_vld   <= w_s_vld_nxt;
            r_s_wr    <= w_s_wr_nxt;
            r_s_addr  <= w_s_addr_nxt;
            r_s_wdata <= w_s_wdata_nxt;
            r_m_ack   <= w_m_ack_nxt;
            r_m_err   <= w_m_err_nxt;
            r_m_rdata <= w_m_rdata_nxt;
            r_busy    <= w_busy_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
        end
    end

    assign s_vld   = r_s_vld;
    assign s_wr    = r_s_wr;
    assign s_addr  = r_s_addr;
    assign s_wdata = r_s_wdata;
    assign m_ack   = r_m_ack;
    assign m_err   = r_m_err;
    assign m_rdata = r_m_rdata;
    assign busy    = r_busy;
    assign gnt_idx = r_gnt;
    assign to_cnt  = r_to_cnt;

endmodule
`default_nettype wire

// File: tb/tb_com_csr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_com_csr_arb
// Description : Self-checking bench for com_csr_arb (3 masters, TIMEOUT 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_com_csr_arb;

    localparam int          NM      = 3;
    localparam int          AW      = 20;
    localparam int          DW      = 32;
    localparam int          TIMEOUT = 8;
    localparam int          IW      = $clog2(NM);
    localparam logic [31:0] ERR     = 32'hDEAD_BEEF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic [NM-1:0]     m_vld = '0;
    logic [NM-1:0]     m_wr = '0;
    logic [NM*AW-1:0]  m_addr = '0;
    logic [NM*DW-1:0]  m_wdata = '0;
    logic [NM-1:0]     m_ack;
    logic              m_err;
    logic [DW-1:0]     m_rdata;
    logic              s_vld, s_wr;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic              s_ack = 1'b0;
    logic [DW-1:0]     s_rdata = '0;
    logic              busy;
    logic [IW-1:0]     gnt_idx;
    logic [15:0]       to_cnt;

    int                tests = 0;
    int                fails = 0;
    int                model_ptr = 0;
    logic [15:0]       exp_to_cnt = '0;
    logic              ex_wr[NM];
    logic [AW-1:0]     ex_addr[NM];
    logic [DW-1:0]     ex_wdata[NM];

    com_csr_arb #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .m_vld(m_vld), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
        .s_vld(s_vld), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata),
        .busy(busy), .gnt_idx(gnt_idx), .to_cnt(to_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus helpers and reference model ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_vld[i] = 1'b1;
        m_wr[i] = wr;
        m_addr[i*AW +: AW] = a;
        m_wdata[i*DW +: DW] = d;
        ex_wr[i] = wr;
        ex_addr[i] = a;
        ex_wdata[i] = d;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
    endtask

    // First requester at or after p, wrapping around the master ring.
    function automatic int pick(input logic [NM-1:0] req, input int p);
        for (int i = 0; i < NM; i++) begin
            if (req[(p + i) % NM]) return (p + i) % NM;
        end
        return -1;
    endfunction

    function automatic logic [NM-1:0] onehot(input int i);
        logic [NM-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        clear = 1'b0;
        m_vld = '0;
        s_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_ptr = 0;
        exp_to_cnt = '0;
    endtask

    // ---------------------------- scenarios ----------------------------
    task automatic test_reset();
        do_reset();
        tests++;
        if ({s_vld, s_wr, s_addr, s_wdata, m_ack, m_err, m_rdata, busy, gnt_idx, to_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_state: s_vld=%b busy=%b gnt=%0d m_ack=%b to_cnt=%0d s_addr=%h m_rdata=%h, required all zero",
                     s_vld, busy, gnt_idx, m_ack, to_cnt, s_addr, m_rdata);
        end
    endtask

    task automatic test_single_read();
        set_req(0, 1'b0, 20'h00010, 32'h0);
        tick();
        tests++;
        if (s_vld !== 1'b1 || gnt_idx !== 0 || s_addr !== 20'h00010 || s_wr !== 1'b0) begin
            fails++;
            $display("FAIL single_grant: s_vld=%b gnt=%0d s_addr=%h s_wr=%b, required 1 0 00010 0", s_vld, gnt_idx, s_addr, s_wr);
        end
        tick();
        tests++;
        if (m_ack !== '0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_wait: m_ack=%b busy=%b, required 000 1", m_ack, busy);
        end
        tick();
        s_ack = 1'b1;
        s_rdata = 32'h1234_5678;
        tick();
        s_ack = 1'b0;
        tests++;
        if (m_ack !== 3'b001 || m_rdata !== 32'h1234_5678 || m_err !== 1'b0 || s_vld !== 1'b0) begin
            fails++;
            $display("FAIL single_resp: m_ack=%b m_rdata=%h m_err=%b s_vld=%b, required 001 12345678 0 0", m_ack, m_rdata, m_err, s_vld);
        end
        m_vld[0] = 1'b0;
        tick();
        tests++;
        if (busy !== 1'b0 || m_ack !== '0 || m_rdata !== 32'h1234_5678) begin
            fails++;
            $display("FAIL single_idle: busy=%b m_ack=%b m_rdata=%h, required 0 000 12345678", busy, m_ack, m_rdata);
        end
        model_ptr = 1;
    endtask

    task automatic test_simultaneous();
        do_reset();
        rand_req(0);
        rand_req(1);
        tick();
        tests++;
        if (s_vld !== 1'b1 || gnt_idx !== 0 || {s_wr, s_addr, s_wdata} !== {ex_wr[0], ex_addr[0], ex_wdata[0]}) begin
            fails++;
            $display("FAIL simul_first: s_vld=%b gnt=%0d s_addr=%h, required 1 0 %h", s_vld, gnt_idx, s_addr, ex_addr[0]);
        end
        s_ack = 1'b1;
        s_rdata = '0;
        tick();
        s_ack = 1'b0;
        tests++;
        if (m_ack !== 3'b001) begin
            fails++;
            $display("FAIL simul_ack0: m_ack=%b required 001", m_ack);
        end
        m_vld[0] = 1'b0;
        tick();
        tests++;
        if (s_vld !== 1'b0) begin
            fails++;
            $display("FAIL simul_gap: s_vld=%b required 0 two cycles after s_ack", s_vld);
        end
        tick();
        tests++;
        if (s_vld !== 1'b1 || gnt_idx !== 1 || {s_wr, s_addr, s_wdata} !== {ex_wr[1], ex_addr[1], ex_wdata[1]}) begin
            fails++;
            $display("FAIL simul_second: s_vld=%b gnt=%0d s_addr=%h, required 1 1 %h (3 cycles after s_ack)", s_vld, gnt_idx, s_addr, ex_addr[1]);
        end
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        tests++;
        if (m_ack !== 3'b010) begin
            fails++;
            $display("FAIL simul_ack1: m_ack=%b required 010", m_ack);
        end
        m_vld[1] = 1'b0;
        tick();
        tick();
        model_ptr = 2;
    endtask

    task automatic test_fairness();
        int exp;
        int prev;
        int wait_ticks;
        prev = -1;
        wait_ticks = 1;
        rand_req(0);
        rand_req(1);
        for (int t = 0; t < 10; t++) begin
            exp = pick(m_vld, model_ptr);
            for (int n = 1; n <= wait_ticks; n++) tick();
            tests++;
            if (s_vld !== 1'b1 || gnt_idx !== IW'(exp) || s_addr !== ex_addr[exp]) begin
                fails++;
                $display("FAIL fair_grant txn %0d: s_vld=%b gnt=%0d s_addr=%h, required 1 %0d %h", t, s_vld, gnt_idx, s_addr, exp, ex_addr[exp]);
            end
            if (t > 0) begin
                tests++;
                if (int'(gnt_idx) == prev) begin
                    fails++;
                    $display("FAIL fair_repeat txn %0d: gnt=%0d served twice in a row, required other master", t, gnt_idx);
                end
            end
            prev = int'(gnt_idx);
            s_ack = 1'b1;
            s_rdata = '0;
            tick();
            s_ack = 1'b0;
            tests++;
            if (m_ack !== onehot(exp)) begin
                fails++;
                $display("FAIL fair_ack txn %0d: m_ack=%b required %b", t, m_ack, onehot(exp));
            end
            model_ptr = (exp + 1) % NM;
            wait_ticks = 2;
        end
        m_vld = '0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int exp;
        rand_req(1);
        m_wr[1] = 1'b1;
        ex_wr[1] = 1'b1;
        exp = pick(m_vld, model_ptr);
        tick();
        tests++;
        if (s_vld !== 1'b1 || gnt_idx !== IW'(exp)) begin
            fails++;
            $display("FAIL to_grant: s_vld=%b gnt=%0d, required 1 %0d", s_vld, gnt_idx, exp);
        end
        for (int n = 1; n <= TIMEOUT; n++) begin
            tick();
            if (n < TIMEOUT) begin
                tests++;
                if (m_ack !== '0 || s_vld !== 1'b1) begin
                    fails++;
                    $display("FAIL to_early cycle %0d: m_ack=%b s_vld=%b, required 000 1", n, m_ack, s_vld);
                end
            end
        end
        exp_to_cnt = exp_to_cnt + 1'b1;
        tests++;
        if (m_ack !== onehot(exp) || m_err !== 1'b1 || m_rdata !== ERR || s_vld !== 1'b0 || to_cnt !== 16'd1) begin
            fails++;
            $display("FAIL to_resp: m_ack=%b m_err=%b m_rdata=%h s_vld=%b to_cnt=%0d, required %b 1 deadbeef 0 1",
                     m_ack, m_err, m_rdata, s_vld, to_cnt, onehot(exp));
        end
        model_ptr = (exp + 1) % NM;
        m_vld = '0;
        s_ack = 1'b1;  // late ack during the DONE bubble must be dropped
        s_rdata = 32'h5555_AAAA;
        tick();
        s_ack = 1'b0;
        tests++;
        if (m_ack !== '0 || busy !== 1'b0 || m_rdata !== ERR) begin
            fails++;
            $display("FAIL to_late_ack: m_ack=%b busy=%b m_rdata=%h, required 000 0 deadbeef", m_ack, busy, m_rdata);
        end
        tick();
        // s_ack lands in the timeout cycle itself: normal completion
        set_req(0, 1'b0, AW'($urandom), DW'($urandom));
        exp = pick(m_vld, model_ptr);
        tick();
        for (int n = 1; n <= TIMEOUT; n++) begin
            s_ack = (n == TIMEOUT);
            s_rdata = 32'hC0DE_0042;
            tick();
        end
        s_ack = 1'b0;
        tests++;
        if (m_ack !== onehot(exp) || m_err !== 1'b0 || m_rdata !== 32'hC0DE_0042 || to_cnt !== exp_to_cnt) begin
            fails++;
            $display("FAIL to_ack_race: m_ack=%b m_err=%b m_rdata=%h to_cnt=%0d, required %b 0 c0de0042 %0d",
                     m_ack, m_err, m_rdata, to_cnt, onehot(exp), exp_to_cnt);
        end
        model_ptr = (exp + 1) % NM;
        m_vld = '0;
        tick();
        tick();
    endtask

    task automatic test_abort();
        do_reset();
        rand_req(0);
        tick();
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        m_vld = '0;
        tick();
        rand_req(0);
        rand_req(1);
        tick();
        tests++;
        if (s_vld !== 1'b1 || gnt_idx !== 1) begin
            fails++;
            $display("FAIL abort_setup: s_vld=%b gnt=%0d, required 1 1", s_vld, gnt_idx);
        end
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_vld = '0;
        tests++;
        if ({s_vld, busy, gnt_idx, m_ack, to_cnt} !== '0) begin
            fails++;
            $display("FAIL abort_clear: s_vld=%b busy=%b gnt=%0d m_ack=%b to_cnt=%0d, required all 0", s_vld, busy, gnt_idx, m_ack, to_cnt);
        end
        for (int n = 0; n < 3; n++) begin
            tick();
            tests++;
            if (m_ack !== '0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL abort_quiet cycle %0d: m_ack=%b busy=%b, required 000 0", n, m_ack, busy);
            end
        end
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        tests++;
        if (m_ack !== '0 || busy !== 1'b0 || s_vld !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle_ack: m_ack=%b busy=%b s_vld=%b, required 000 0 0", m_ack, busy, s_vld);
        end
        rand_req(0);
        rand_req(1);
        tick();
        tests++;
        if (s_vld !== 1'b1 || gnt_idx !== 0) begin
            fails++;
            $display("FAIL abort_ptr_clear: s_vld=%b gnt=%0d, required 1 0", s_vld, gnt_idx);
        end
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        m_vld[0] = 1'b0;
        tick();
        tick();
        // master 1 now in BUSY; hit it with the asynchronous reset
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({s_vld, busy, gnt_idx, m_ack} !== '0) begin
            fails++;
            $display("FAIL abort_rst: s_vld=%b busy=%b gnt=%0d m_ack=%b, required all 0", s_vld, busy, gnt_idx, m_ack);
        end
        #1 rst = 1'b0;
        m_vld = '0;
        tick();
        tests++;
        if (m_ack !== '0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_rst_quiet: m_ack=%b busy=%b, required 000 0", m_ack, busy);
        end
        rand_req(0);
        rand_req(1);
        tick();
        tests++;
        if (s_vld !== 1'b1 || gnt_idx !== 0) begin
            fails++;
            $display("FAIL abort_ptr_rst: s_vld=%b gnt=%0d, required 1 0", s_vld, gnt_idx);
        end
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        m_vld = '0;
        tick();
        tick();
    endtask

    task automatic test_random(input int ntx);
        int exp, lat, exp_n, wait_ticks;
        logic iserr;
        logic [DW-1:0] rd, exp_rd;
        do_reset();
        for (int i = 0; i < NM; i++) if ($urandom_range(0, 1) == 1) rand_req(i);
        if (m_vld == '0) rand_req(0);
        wait_ticks = 1;
        for (int t = 0; t < ntx; t++) begin
            exp = pick(m_vld, model_ptr);
            for (int n = 1; n <= wait_ticks; n++) begin
                tick();
                tests++;
                if (s_vld !== (n == wait_ticks)) begin
                    fails++;
                    $display("FAIL rnd_svld_timing txn %0d: s_vld=%b required %b", t, s_vld, (n == wait_ticks));
                end
            end
            tests++;
            if (gnt_idx !== IW'(exp) || busy !== 1'b1) begin
                fails++;
                $display("FAIL rnd_grant txn %0d: gnt=%0d busy=%b, required %0d 1", t, gnt_idx, busy, exp);
            end
            tests++;
            if ({s_wr, s_addr, s_wdata} !== {ex_wr[exp], ex_addr[exp], ex_wdata[exp]}) begin
                fails++;
                $display("FAIL rnd_fields txn %0d: wr=%b addr=%h wdata=%h, required %b %h %h",
                         t, s_wr, s_addr, s_wdata, ex_wr[exp], ex_addr[exp], ex_wdata[exp]);
            end
            lat = $urandom_range(1, TIMEOUT + 2);
            iserr = (lat > TIMEOUT);
            exp_n = iserr ? TIMEOUT : lat;
            rd = DW'($urandom);
            for (int n = 1; n <= exp_n; n++) begin
                s_ack = (n == lat);
                s_rdata = (n == lat) ? (ex_wr[exp] ? '0 : rd) : DW'($urandom);
                tick();
                if (n < exp_n) begin
                    tests++;
                    if (m_ack !== '0 || s_vld !== 1'b1) begin
                        fails++;
                        $display("FAIL rnd_wait txn %0d cycle %0d: m_ack=%b s_vld=%b, required 000 1", t, n, m_ack, s_vld);
                    end
                end
            end
            s_ack = 1'b0;
            if (iserr && exp_to_cnt != 16'hFFFF) exp_to_cnt = exp_to_cnt + 1'b1;
            exp_rd = iserr ? ERR : (ex_wr[exp] ? '0 : rd);
            tests++;
            if (m_ack !== onehot(exp) || m_err !== iserr) begin
                fails++;
                $display("FAIL rnd_ack txn %0d lat %0d: m_ack=%b m_err=%b, required %b %b", t, lat, m_ack, m_err, onehot(exp), iserr);
            end
            tests++;
            if (m_rdata !== exp_rd || s_vld !== 1'b0 || to_cnt !== exp_to_cnt) begin
                fails++;
                $display("FAIL rnd_resp txn %0d: m_rdata=%h s_vld=%b to_cnt=%0d, required %h 0 %0d", t, m_rdata, s_vld, to_cnt, exp_rd, exp_to_cnt);
            end
            model_ptr = (exp + 1) % NM;
            m_vld[exp] = 1'b0;
            for (int i = 0; i < NM; i++) if (!m_vld[i] && $urandom_range(0, 1) == 1) rand_req(i);
            if (m_vld == '0) rand_req(int'($urandom_range(0, NM - 1)));
            wait_ticks = 2;
        end
        m_vld = '0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_abort();
        test_random(40);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/com_csr_arb.md
# com_csr_arb

Round-robin arbiter that shares one CSR slave port between `NM` CSR masters, for example the AHB-derived CSR path and a debug CSR path feeding one `*_csr_slave` register block. It serialises requests one at a time and forwards each granted request to the slave. It returns the slave's acknowledge and read data to the owning master. A timeout counter completes any transaction the slave never acknowledges with an error response, so a master cannot hang.

## Interface
Parameters:
- `NM`, 2: number of masters, 2..8.
- `AW`, 20: CSR address width.
- `DW`, 32: CSR data width.
- `TIMEOUT`, 255: cycles to wait for `s_ack` before completing with an error. 0 disables the timeout. Max 65535.
- `ERR_DATA`, 32'hDEAD_BEEF: value returned on `m_rdata` with an error response.

Ports:
- `clk` in 1: single clock. All logic is in this domain.
- `rst` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous clear with the same effect as reset.
- `m_vld` in NM: per-master request. Held high, with its fields stable, until that master's `m_ack`.
- `m_wr` in NM: per-master direction. 1 = write, 0 = read.
- `m_addr` in NM*AW: per-master address. Master i owns `[i*AW +: AW]`.
- `m_wdata` in NM*DW: per-master write data, packed the same way.
- `m_ack` out NM: one-cycle completion pulse to the owning master.
- `m_err` out 1: qualifies `m_ack`. 1 = timeout error.
- `m_rdata` out DW: read data, broadcast to all masters, valid only with `m_ack`.
- `s_vld` out 1: request to the slave. Held until `s_ack` or timeout.
- `s_wr` out 1: direction to the slave.
- `s_addr` out AW: address to the slave.
- `s_wdata` out DW: write data to the slave.
- `s_ack` in 1: slave completion pulse.
- `s_rdata` in DW: slave read data, valid with `s_ack`.
- `busy` out 1: high in any state other than IDLE.
- `gnt_idx` out clog2(NM): index of the current or most recent grant.
- `to_cnt` out 16: saturating count of timeouts.

## Operation
FSM states are IDLE, BUSY and DONE. All outputs are registered.

Reset or `clear` sets every output to 0: `s_*`, `m_ack`, `m_err`, `m_rdata`, `busy`, `gnt_idx` and `to_cnt`. It also sets the round-robin pointer `ptr` to 0, the wait counter to 0, and the state to IDLE.

IDLE:
- If any `m_vld` is high, grant the first requesting master found searching from `ptr` upward with wrap (ptr, ptr+1, …, NM-1, 0, …).
- On grant, latch `gnt_idx` and load `s_wr`, `s_addr` and `s_wdata` from the granted master's fields.
- Also on grant, set `s_vld` to 1, clear the wait counter, and move to BUSY.
- If `s_ack` arrives while in IDLE, ignore it.

BUSY:
- The wait counter increments every cycle.
- On `s_ack`: set `s_vld` to 0, set `m_rdata` to `s_rdata` (which is 0 for a write), set `m_err` to 0, pulse `m_ack[gnt_idx]`, and move to DONE.
- If `TIMEOUT` is not 0, `s_ack` is 0, and the counter equals `TIMEOUT`-1: set `s_vld` to 0, set `m_rdata` to `ERR_DATA`, set `m_err` to 1, pulse `m_ack[gnt_idx]`, increment `to_cnt` (saturating at 0xFFFF), and move to DONE.
- If `s_ack` and the timeout fall in the same cycle, `s_ack` wins and there is no error.

DONE:
- This is a one-cycle bubble. It lets the acknowledged master drop `m_vld` before the next arbitration.
- Set `ptr` to `gnt_idx`+1, wrapping to 0 when it reaches NM.
- Clear `m_ack` and `m_err` and move to IDLE. `m_rdata` holds its value.

General rules:
- Only one transaction is outstanding at a time. Ungranted masters simply wait.
- `clear` or `rst` during BUSY aborts the transaction: `s_vld` drops and no `m_ack` is issued. The master re-requests on its own.
- Late `s_ack` after a timeout: a late ack received in DONE or IDLE is dropped. The slave must not ack a request it saw deasserted.

## Timing
- A request sampled in IDLE at cycle t produces `s_vld` = 1 at t+1.
- `s_ack` at cycle k produces `m_ack` at k+1. Best case is `s_ack` at t+1, giving `m_ack` at t+2.
- DONE is cycle k+1, IDLE is k+2, and the next `s_vld` is at k+3. Back-to-back throughput is one transaction per 3 cycles plus the slave latency.
- On timeout, `s_vld` rises at t+1 and `m_ack` with `m_err` = 1 occurs at t+1+`TIMEOUT`.
- `m_ack` is always exactly one cycle wide and one-hot, or all zeros.

## Test plan
- Single read: master 0 reads addr 0x00010; the slave acks 2 cycles after `s_vld` with 0x1234_5678. Required: `m_ack[0]` one cycle after `s_ack`, `m_rdata` = 0x1234_5678, `m_err` = 0, `busy` low again 2 cycles after `s_ack`.
- Simultaneous requests: masters 0 and 1 assert in the same cycle from reset. Required: master 0 is served first, then master 1. The second `s_vld` rises 3 cycles after the first `s_ack`.
- Fairness: both masters request continuously for 10 transactions. Required: grants alternate 0,1,0,1 with no master served twice in a row.
- Timeout: `TIMEOUT` = 8 and the slave never acks. Required: `m_ack` with `m_err` = 1 and `m_rdata` = 0xDEAD_BEEF exactly 8 cycles after `s_vld` rose, `s_vld` low, `to_cnt` = 1. Also check an `s_ack` arriving in the timeout cycle: it completes with `m_err` = 0.
- Abort: assert `clear` for one cycle while in BUSY, then separately assert `rst` mid-transaction. Required: `s_vld`, `busy`, `gnt_idx` and `ptr` reset to 0 and no `m_ack` pulse. A later `s_ack` in IDLE is ignored.
